// File: rtl/pipeline_registers.sv
// ----------------------------------------------------------------------------
// pipeline_registers
//
// Inter-stage register bank for the 5-stage RISC-V core. Holds the IF/ID,
// ID/EX, EX/MEM and MEM/WB state between pipeline stages. Every output is a
// plain flop of its corresponding input; no combinational input-to-output
// path exists.
//
// Hazard control (per clk edge, highest priority first):
//   reset low  -> every register cleared, all valids 0
//   flush high -> IF/ID and ID/EX cleared; EX/MEM and MEM/WB load
//   stall high -> IF/ID and ID/EX hold;    EX/MEM and MEM/WB load
//   otherwise  -> all four stages load
//
// Build option:
//   PIPE_STALL_BUBBLE_EN  when defined, EX/MEM loads an all-zero bubble while
//                         stall=1 and flush=0, so the frozen ID/EX instruction
//                         is not issued twice. MEM/WB is unaffected.
//   CONTROL_SIGNALS_WIDTH default for CTRL_WIDTH (16 when undefined).
//
// Ports:
//   clk, reset (sync, active-low), stall, flush
//   if_*        IF/ID inputs             id_*          IF/ID outputs
//   id_*_in     ID/EX inputs             ex_*          ID/EX outputs
//   ex_*_in     EX/MEM inputs            mem_*         EX/MEM outputs
//   mem_*_in    MEM/WB inputs            wb_*          MEM/WB outputs
// ----------------------------------------------------------------------------

`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 16
`endif

module pipeline_registers #(
    parameter int unsigned CTRL_WIDTH = `CONTROL_SIGNALS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,

    // IF/ID
    input  logic [31:0]           if_pc,
    input  logic [31:0]           if_instruction,
    input  logic                  if_valid,
    output logic [31:0]           id_pc,
    output logic [31:0]           id_instruction,
    output logic                  id_valid,

    // ID/EX
    input  logic [31:0]           id_pc_in,
    input  logic [31:0]           id_instruction_in,
    input  logic [31:0]           id_rs1_data_in,
    input  logic [31:0]           id_rs2_data_in,
    input  logic [31:0]           id_immediate_in,
    input  logic [4:0]            id_rd_addr_in,
    input  logic [4:0]            id_rs1_addr_in,
    input  logic [4:0]            id_rs2_addr_in,
    input  logic [CTRL_WIDTH-1:0] id_control_signals_in,
    input  logic                  id_valid_in,
    output logic [31:0]           ex_pc,
    output logic [31:0]           ex_instruction,
    output logic [31:0]           ex_rs1_data,
    output logic [31:0]           ex_rs2_data,
    output logic [31:0]           ex_immediate,
    output logic [4:0]            ex_rd_addr,
    output logic [4:0]            ex_rs1_addr,
    output logic [4:0]            ex_rs2_addr,
    output logic [CTRL_WIDTH-1:0] ex_control_signals,
    output logic                  ex_valid,

    // EX/MEM
    input  logic [31:0]           ex_pc_in,
    input  logic [31:0]           ex_alu_result_in,
    input  logic [31:0]           ex_rs2_data_in,
    input  logic [4:0]            ex_rd_addr_in,
    input  logic [CTRL_WIDTH-1:0] ex_control_signals_in,
    input  logic                  ex_valid_in,
    output logic [31:0]           mem_pc,
    output logic [31:0]           mem_alu_result,
    output logic [31:0]           mem_rs2_data,
    output logic [4:0]            mem_rd_addr,
    output logic [CTRL_WIDTH-1:0] mem_control_signals,
    output logic                  mem_valid,

    // MEM/WB
    input  logic [31:0]           mem_pc_in,
    input  logic [31:0]           mem_alu_result_in,
    input  logic [31:0]           mem_mem_data_in,
    input  logic [4:0]            mem_rd_addr_in,
    input  logic [CTRL_WIDTH-1:0] mem_control_signals_in,
    input  logic                  mem_valid_in,
    output logic [31:0]           wb_pc,
    output logic [31:0]           wb_alu_result,
    output logic [31:0]           wb_mem_data,
    output logic [4:0]            wb_rd_addr,
    output logic [CTRL_WIDTH-1:0] wb_control_signals,
    output logic                  wb_valid
);

    // ------------------------------------------------------------------------
    // Stage record types
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           instr;
        logic [31:0]           rs1_data;
        logic [31:0]           rs2_data;
        logic [31:0]           imm;
        logic [4:0]            rd_addr;
        logic [4:0]            rs1_addr;
        logic [4:0]            rs2_addr;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic                  valid;
    } idex_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           alu_result;
        logic [31:0]           rs2_data;
        logic [4:0]            rd_addr;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic                  valid;
    } exmem_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           alu_result;
        logic [31:0]           mem_data;
        logic [4:0]            rd_addr;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic                  valid;
    } memwb_t;

    ifid_t  ifid_in,  ifid_d,  ifid_q;
    idex_t  idex_in,  idex_d,  idex_q;
    exmem_t exmem_in, exmem_d, exmem_q;
    memwb_t memwb_in, memwb_d, memwb_q;

    // ------------------------------------------------------------------------
    // Gather incoming stage records
    // ------------------------------------------------------------------------
    always_comb begin
        ifid_in.pc    = if_pc;
        ifid_in.instr = if_instruction;
        ifid_in.valid = if_valid;
    end

    always_comb begin
        idex_in.pc       = id_pc_in;
        idex_in.instr    = id_instruction_in;
        idex_in.rs1_data = id_rs1_data_in;
        idex_in.rs2_data = id_rs2_data_in;
        idex_in.imm      = id_immediate_in;
        idex_in.rd_addr  = id_rd_addr_in;
        idex_in.rs1_addr = id_rs1_addr_in;
        idex_in.rs2_addr = id_rs2_addr_in;
        idex_in.ctrl     = id_control_signals_in;
        idex_in.valid    = id_valid_in;
    end

    always_comb begin
        exmem_in.pc         = ex_pc_in;
        exmem_in.alu_result = ex_alu_result_in;
        exmem_in.rs2_data   = ex_rs2_data_in;
        exmem_in.rd_addr    = ex_rd_addr_in;
        exmem_in.ctrl       = ex_control_signals_in;
        exmem_in.valid      = ex_valid_in;
    end

    always_comb begin
        memwb_in.pc         = mem_pc_in;
        memwb_in.alu_result = mem_alu_result_in;
        memwb_in.mem_data   = mem_mem_data_in;
        memwb_in.rd_addr    = mem_rd_addr_in;
        memwb_in.ctrl       = mem_control_signals_in;
        memwb_in.valid      = mem_valid_in;
    end

    // ------------------------------------------------------------------------
    // Next-state selection. Reset is applied in the register process, so this
    // only resolves flush > stall > normal load.
    // ------------------------------------------------------------------------
    always_comb begin
        ifid_d  = ifid_q;
        idex_d  = idex_q;
        exmem_d = exmem_in;
        memwb_d = memwb_in;

        if (flush) begin
            ifid_d = '0;
            idex_d = '0;
        end else if (stall) begin
`ifdef PIPE_STALL_BUBBLE_EN
            // Front half is frozen; inject a bubble so the held ID/EX
            // instruction does not reach MEM a second time.
            exmem_d = '0;
`else
            exmem_d = exmem_in;
`endif
        end else begin
            ifid_d = ifid_in;
            idex_d = idex_in;
        end
    end

    // ------------------------------------------------------------------------
    // Stage registers, synchronous active-low reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign id_pc              = ifid_q.pc;
    assign id_instruction     = ifid_q.instr;
    assign id_valid           = ifid_q.valid;

    assign ex_pc              = idex_q.pc;
    assign ex_instruction     = idex_q.instr;
    assign ex_rs1_data        = idex_q.rs1_data;
    assign ex_rs2_data        = idex_q.rs2_data;
    assign ex_immediate       = idex_q.imm;
    assign ex_rd_addr         = idex_q.rd_addr;
    assign ex_rs1_addr        = idex_q.rs1_addr;
    assign ex_rs2_addr        = idex_q.rs2_addr;
    assign ex_control_signals = idex_q.ctrl;
    assign ex_valid           = idex_q.valid;

    assign mem_pc              = exmem_q.pc;
    assign mem_alu_result      = exmem_q.alu_result;
    assign mem_rs2_data        = exmem_q.rs2_data;
    assign mem_rd_addr         = exmem_q.rd_addr;
    assign mem_control_signals = exmem_q.ctrl;
    assign mem_valid           = exmem_q.valid;

    assign wb_pc              = memwb_q.pc;
    assign wb_alu_result      = memwb_q.alu_result;
    assign wb_mem_data        = memwb_q.mem_data;
    assign wb_rd_addr         = memwb_q.rd_addr;
    assign wb_control_signals = memwb_q.ctrl;
    assign wb_valid           = memwb_q.valid;

endmodule

// File: tb/tb_pipeline_registers.sv
// ----------------------------------------------------------------------------
// tb_pipeline_registers
//
// Self-checking bench for pipeline_registers: directed scenarios for reset,
// propagation, stall, flush, flush+stall and reset-during-stall, followed by
// randomized traffic compared against a stage-vector reference model.
// Honours PIPE_STALL_BUBBLE_EN when set for the build.
// ----------------------------------------------------------------------------

module tb_pipeline_registers;

    localparam int CW       = 16;
    localparam int IFID_W   = 65;
    localparam int IDEX_W   = 5*32 + 3*5 + CW + 1;
    localparam int EXMEM_W  = 3*32 + 5 + CW + 1;
    localparam int MEMWB_W  = 3*32 + 5 + CW + 1;

`ifdef PIPE_STALL_BUBBLE_EN
    localparam bit BUBBLE = 1'b1;
`else
    localparam bit BUBBLE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, stall, flush;

    logic [31:0]   if_pc, if_instruction;
    logic          if_valid;
    logic [31:0]   id_pc, id_instruction;
    logic          id_valid;

    logic [31:0]   id_pc_in, id_instruction_in, id_rs1_data_in, id_rs2_data_in, id_immediate_in;
    logic [4:0]    id_rd_addr_in, id_rs1_addr_in, id_rs2_addr_in;
    logic [CW-1:0] id_control_signals_in;
    logic          id_valid_in;
    logic [31:0]   ex_pc, ex_instruction, ex_rs1_data, ex_rs2_data, ex_immediate;
    logic [4:0]    ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
    logic [CW-1:0] ex_control_signals;
    logic          ex_valid;

    logic [31:0]   ex_pc_in, ex_alu_result_in, ex_rs2_data_in;
    logic [4:0]    ex_rd_addr_in;
    logic [CW-1:0] ex_control_signals_in;
    logic          ex_valid_in;
    logic [31:0]   mem_pc, mem_alu_result, mem_rs2_data;
    logic [4:0]    mem_rd_addr;
    logic [CW-1:0] mem_control_signals;
    logic          mem_valid;

    logic [31:0]   mem_pc_in, mem_alu_result_in, mem_mem_data_in;
    logic [4:0]    mem_rd_addr_in;
    logic [CW-1:0] mem_control_signals_in;
    logic          mem_valid_in;
    logic [31:0]   wb_pc, wb_alu_result, wb_mem_data;
    logic [4:0]    wb_rd_addr;
    logic [CW-1:0] wb_control_signals;
    logic          wb_valid;

    pipeline_registers #(.CTRL_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .if_pc(if_pc), .if_instruction(if_instruction), .if_valid(if_valid),
        .id_pc(id_pc), .id_instruction(id_instruction), .id_valid(id_valid),
        .id_pc_in(id_pc_in), .id_instruction_in(id_instruction_in),
        .id_rs1_data_in(id_rs1_data_in), .id_rs2_data_in(id_rs2_data_in),
        .id_immediate_in(id_immediate_in), .id_rd_addr_in(id_rd_addr_in),
        .id_rs1_addr_in(id_rs1_addr_in), .id_rs2_addr_in(id_rs2_addr_in),
        .id_control_signals_in(id_control_signals_in), .id_valid_in(id_valid_in),
        .ex_pc(ex_pc), .ex_instruction(ex_instruction), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_immediate(ex_immediate), .ex_rd_addr(ex_rd_addr),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_control_signals(ex_control_signals), .ex_valid(ex_valid),
        .ex_pc_in(ex_pc_in), .ex_alu_result_in(ex_alu_result_in),
        .ex_rs2_data_in(ex_rs2_data_in), .ex_rd_addr_in(ex_rd_addr_in),
        .ex_control_signals_in(ex_control_signals_in), .ex_valid_in(ex_valid_in),
        .mem_pc(mem_pc), .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
        .mem_rd_addr(mem_rd_addr), .mem_control_signals(mem_control_signals),
        .mem_valid(mem_valid),
        .mem_pc_in(mem_pc_in), .mem_alu_result_in(mem_alu_result_in),
        .mem_mem_data_in(mem_mem_data_in), .mem_rd_addr_in(mem_rd_addr_in),
        .mem_control_signals_in(mem_control_signals_in), .mem_valid_in(mem_valid_in),
        .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_rd_addr(wb_rd_addr), .wb_control_signals(wb_control_signals),
        .wb_valid(wb_valid)
    );

    // Whole-stage views of the inputs and outputs
    logic [IFID_W-1:0]  in_ifid,  out_ifid,  m_ifid;
    logic [IDEX_W-1:0]  in_idex,  out_idex,  m_idex;
    logic [EXMEM_W-1:0] in_exmem, out_exmem, m_exmem;
    logic [MEMWB_W-1:0] in_memwb, out_memwb, m_memwb;

    assign in_ifid   = {if_pc, if_instruction, if_valid};
    assign out_ifid  = {id_pc, id_instruction, id_valid};
    assign in_idex   = {id_pc_in, id_instruction_in, id_rs1_data_in, id_rs2_data_in,
                        id_immediate_in, id_rd_addr_in, id_rs1_addr_in, id_rs2_addr_in,
                        id_control_signals_in, id_valid_in};
    assign out_idex  = {ex_pc, ex_instruction, ex_rs1_data, ex_rs2_data, ex_immediate,
                        ex_rd_addr, ex_rs1_addr, ex_rs2_addr, ex_control_signals, ex_valid};
    assign in_exmem  = {ex_pc_in, ex_alu_result_in, ex_rs2_data_in, ex_rd_addr_in,
                        ex_control_signals_in, ex_valid_in};
    assign out_exmem = {mem_pc, mem_alu_result, mem_rs2_data, mem_rd_addr,
                        mem_control_signals, mem_valid};
    assign in_memwb  = {mem_pc_in, mem_alu_result_in, mem_mem_data_in, mem_rd_addr_in,
                        mem_control_signals_in, mem_valid_in};
    assign out_memwb = {wb_pc, wb_alu_result, wb_mem_data, wb_rd_addr,
                        wb_control_signals, wb_valid};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: each stage is one opaque word; the control inputs
    // decide whether a word is zeroed, kept, or replaced by its input word.
    task automatic model_edge();
        if (!reset) begin
            m_ifid = '0; m_idex = '0; m_exmem = '0; m_memwb = '0;
        end else begin
            m_memwb = in_memwb;
            if (flush) begin
                m_ifid  = '0;
                m_idex  = '0;
                m_exmem = in_exmem;
            end else if (stall) begin
                m_exmem = BUBBLE ? '0 : in_exmem;
            end else begin
                m_ifid  = in_ifid;
                m_idex  = in_idex;
                m_exmem = in_exmem;
            end
        end
    endtask

    // One clock edge, then model update and full-stage comparison.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check("ifid",  256'(out_ifid),  256'(m_ifid));
        check("idex",  256'(out_idex),  256'(m_idex));
        check("exmem", 256'(out_exmem), 256'(m_exmem));
        check("memwb", 256'(out_memwb), 256'(m_memwb));
    endtask

    task automatic zero_inputs();
        if_pc = '0; if_instruction = '0; if_valid = 1'b0;
        id_pc_in = '0; id_instruction_in = '0; id_rs1_data_in = '0; id_rs2_data_in = '0;
        id_immediate_in = '0; id_rd_addr_in = '0; id_rs1_addr_in = '0; id_rs2_addr_in = '0;
        id_control_signals_in = '0; id_valid_in = 1'b0;
        ex_pc_in = '0; ex_alu_result_in = '0; ex_rs2_data_in = '0; ex_rd_addr_in = '0;
        ex_control_signals_in = '0; ex_valid_in = 1'b0;
        mem_pc_in = '0; mem_alu_result_in = '0; mem_mem_data_in = '0; mem_rd_addr_in = '0;
        mem_control_signals_in = '0; mem_valid_in = 1'b0;
    endtask

    task automatic random_inputs();
        if_pc = $urandom; if_instruction = $urandom; if_valid = 1'($urandom);
        id_pc_in = $urandom; id_instruction_in = $urandom; id_rs1_data_in = $urandom;
        id_rs2_data_in = $urandom; id_immediate_in = $urandom;
        id_rd_addr_in = 5'($urandom); id_rs1_addr_in = 5'($urandom);
        id_rs2_addr_in = 5'($urandom);
        id_control_signals_in = CW'($urandom); id_valid_in = 1'($urandom);
        ex_pc_in = $urandom; ex_alu_result_in = $urandom; ex_rs2_data_in = $urandom;
        ex_rd_addr_in = 5'($urandom); ex_control_signals_in = CW'($urandom);
        ex_valid_in = 1'($urandom);
        mem_pc_in = $urandom; mem_alu_result_in = $urandom; mem_mem_data_in = $urandom;
        mem_rd_addr_in = 5'($urandom); mem_control_signals_in = CW'($urandom);
        mem_valid_in = 1'($urandom);
    endtask

    // Chain each stage's outputs into the next stage's inputs.
    task automatic forward_stages();
        id_pc_in = id_pc; id_instruction_in = id_instruction; id_valid_in = id_valid;
        ex_pc_in = ex_pc; ex_rd_addr_in = ex_rd_addr;
        ex_control_signals_in = ex_control_signals; ex_valid_in = ex_valid;
        mem_pc_in = mem_pc; mem_alu_result_in = mem_alu_result;
        mem_rd_addr_in = mem_rd_addr; mem_control_signals_in = mem_control_signals;
        mem_valid_in = mem_valid;
    endtask

    initial begin
        m_ifid = '0; m_idex = '0; m_exmem = '0; m_memwb = '0;
        stall = 1'b0; flush = 1'b0;

        // Reset with random garbage on the inputs
        reset = 1'b0;
        random_inputs();
        tick();
        check("rst_id_pc",  256'(id_pc),  256'(0));
        check("rst_ex_pc",  256'(ex_pc),  256'(0));
        check("rst_mem_pc", 256'(mem_pc), 256'(0));
        check("rst_wb_pc",  256'(wb_pc),  256'(0));
        check("rst_valids", 256'({id_valid, ex_valid, mem_valid, wb_valid}), 256'(0));

        // Propagation through all four stages
        reset = 1'b1;
        zero_inputs();
        if_pc = 32'h1000; if_instruction = 32'hAAAABBBB; if_valid = 1'b1;
        tick();
        check("prop_id_pc", 256'(id_pc), 256'(32'h1000));
        check("prop_id_instr", 256'(id_instruction), 256'(32'hAAAABBBB));
        if_pc = '0; if_instruction = '0; if_valid = 1'b0;
        forward_stages();
        tick();
        check("prop_ex_pc", 256'(ex_pc), 256'(32'h1000));
        forward_stages();
        tick();
        check("prop_mem_pc", 256'(mem_pc), 256'(32'h1000));
        forward_stages();
        tick();
        check("prop_wb_pc", 256'(wb_pc), 256'(32'h1000));
        check("prop_wb_valid", 256'(wb_valid), 256'(1));

        // Stall: load, then hold for two cycles, then release
        zero_inputs();
        if_pc = 32'h2000; if_valid = 1'b1; id_pc_in = 32'h1004; id_valid_in = 1'b1;
        tick();
        stall = 1'b1;
        if_pc = 32'h3000; id_pc_in = 32'h2000;
        ex_pc_in = 32'h5000; ex_valid_in = 1'b1; mem_pc_in = 32'h6000; mem_valid_in = 1'b1;
        tick();
        check("stall_id_pc", 256'(id_pc), 256'(32'h2000));
        check("stall_ex_pc", 256'(ex_pc), 256'(32'h1004));
        check("stall_mem_pc", 256'(mem_pc), 256'(BUBBLE ? 32'h0 : 32'h5000));
        check("stall_mem_valid", 256'(mem_valid), 256'(BUBBLE ? 1'b0 : 1'b1));
        check("stall_wb_pc", 256'(wb_pc), 256'(32'h6000));
        tick();
        check("stall2_id_pc", 256'(id_pc), 256'(32'h2000));
        stall = 1'b0;
        tick();
        check("unstall_id_pc", 256'(id_pc), 256'(32'h3000));
        check("unstall_ex_pc", 256'(ex_pc), 256'(32'h2000));

        // Flush with valid inputs everywhere
        flush = 1'b1;
        if_valid = 1'b1; id_valid_in = 1'b1; ex_valid_in = 1'b1; mem_valid_in = 1'b1;
        tick();
        check("flush_id",  256'({id_pc, id_valid}), 256'(0));
        check("flush_ex",  256'({ex_pc, ex_valid}), 256'(0));
        check("flush_mem_valid", 256'(mem_valid), 256'(1));
        check("flush_wb_valid",  256'(wb_valid),  256'(1));

        // Flush and stall together: flush wins
        flush = 1'b0;
        random_inputs();
        if_valid = 1'b1; id_valid_in = 1'b1;
        tick();
        flush = 1'b1; stall = 1'b1;
        tick();
        check("fs_id", 256'(out_ifid), 256'(0));
        check("fs_ex", 256'(out_idex), 256'(0));

        // Reset during stall
        flush = 1'b0; stall = 1'b0;
        random_inputs();
        tick();
        reset = 1'b0; stall = 1'b1;
        random_inputs();
        tick();
        check("rst_stall_all", 256'({out_ifid, out_exmem, out_memwb}), 256'(0));
        check("rst_stall_idex", 256'(out_idex), 256'(0));

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 19) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            random_inputs();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
